// File: rtl/gcm_ghash_engine.sv
// Iterative GHASH multiplier for AES-GCM: Y <= (Y ^ X) * H in GF(2^128).
// Processes BITS_PER_CYCLE multiplier bits per clock, so one block takes 128/BITS_PER_CYCLE cycles.
module gcm_ghash_engine #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init,
    input  logic [127:0] h_key,
    input  logic         blk_valid,
    input  logic [127:0] blk_data,
    output logic         blk_ready,
    output logic         busy,
    output logic [127:0] y_out,
    output logic         y_valid
);

    localparam int          L    = 128 / BITS_PER_CYCLE;
    localparam logic [6:0]  LAST = 7'(L - 1);
    localparam logic [127:0] R   = 128'hE1000000_00000000_00000000_00000000;

    typedef enum logic [0:0] {IDLE, MUL} state_t;

    state_t       state;
    logic [127:0] h_reg;
    logic [127:0] y_reg;
    logic [127:0] x_reg;
    logic [127:0] z_reg;
    logic [127:0] v_reg;
    logic [6:0]   cnt;

    logic [127:0] x_next;
    logic [127:0] z_next;
    logic [127:0] v_next;

    // X is shifted left each round so its MSB is always the next multiplier bit.
    always_comb begin
        x_next = x_reg;
        z_next = z_reg;
        v_next = v_reg;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (x_next[127]) begin
                z_next = z_next ^ v_next;
            end
            v_next = v_next[0] ? ((v_next >> 1) ^ R) : (v_next >> 1);
            x_next = {x_next[126:0], 1'b0};
        end
    end

    assign blk_ready = (state == IDLE) && !init;
    assign busy      = (state == MUL);
    assign y_out     = y_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            h_reg   <= '0;
            y_reg   <= '0;
            x_reg   <= '0;
            z_reg   <= '0;
            v_reg   <= '0;
            cnt     <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            if (init) begin
                h_reg <= h_key;
                y_reg <= '0;
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (blk_valid) begin
                            x_reg <= y_reg ^ blk_data;
                            z_reg <= '0;
                            v_reg <= h_reg;
                            cnt   <= '0;
                            state <= MUL;
                        end
                    end
                    MUL: begin
                        x_reg <= x_next;
                        z_reg <= z_next;
                        v_reg <= v_next;
                        if (cnt == LAST) begin
                            y_reg   <= z_next;
                            y_valid <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            cnt <= cnt + 7'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gcm_ghash_engine.sv
// Scoreboard bench for gcm_ghash_engine: directed blocks push expected Y and arrival cycle,
// per-instance monitors pop and compare on every y_valid pulse.
module tb_gcm_ghash_engine;

    localparam logic [128-1:0] H_ONE  = 128'h80000000_00000000_00000000_00000000;
    localparam logic [128-1:0] X_ID   = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [128-1:0] B_ID   = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
    localparam logic [128-1:0] XB_ID  = 128'hFEDCBA98_89ABCDEF_01234567_76543210;
    localparam logic [128-1:0] X_RED  = 128'h40000000_00000000_00000000_00000000;
    localparam logic [128-1:0] Y_RED  = 128'hE1000000_00000000_00000000_00000000;
    localparam logic [128-1:0] H_NIST = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [128-1:0] X_NIST = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [128-1:0] Y_NIST = 128'h5e2ec746917062882c85b0685353deb7;
    localparam logic [128-1:0] A_BP   = 128'h11111111_22222222_33333333_44444444;
    localparam logic [128-1:0] B_BP   = 128'h10101010_20202020_30303030_40404040;
    localparam logic [128-1:0] AB_BP  = 128'h01010101_02020202_03030303_04040404;

    typedef struct {
        logic [127:0] y;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         init;
    logic [127:0] h_key;
    logic         blk_valid;
    logic         blk_valid_fast;
    logic [127:0] blk_data;

    logic         ready1, busy1, yv1;
    logic [127:0] y1;
    logic         ready4, busy4, yv4;
    logic [127:0] y4;
    logic         ready16, busy16, yv16;
    logic [127:0] y16;

    exp_t q1[$];
    exp_t q4[$];
    exp_t q16[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    gcm_ghash_engine #(.BITS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .init(init), .h_key(h_key),
        .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(ready1),
        .busy(busy1), .y_out(y1), .y_valid(yv1)
    );

    gcm_ghash_engine #(.BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .init(init), .h_key(h_key),
        .blk_valid(blk_valid_fast), .blk_data(blk_data), .blk_ready(ready4),
        .busy(busy4), .y_out(y4), .y_valid(yv4)
    );

    gcm_ghash_engine #(.BITS_PER_CYCLE(16)) dut16 (
        .clk(clk), .rst(rst), .init(init), .h_key(h_key),
        .blk_valid(blk_valid_fast), .blk_data(blk_data), .blk_ready(ready16),
        .busy(busy16), .y_out(y16), .y_valid(yv16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        total++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic reportFailure(input string name);
        total++;
        $display("[TB] FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (yv1) begin
            if (q1.size() == 0) begin
                reportFailure("dut1 unexpected y_valid");
            end else begin
                e = q1.pop_front();
                checkOutput("dut1 y_out", y1, e.y);
                checkOutput("dut1 y_valid cycle", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (yv4) begin
            if (q4.size() == 0) begin
                reportFailure("dut4 unexpected y_valid");
            end else begin
                e = q4.pop_front();
                checkOutput("dut4 y_out", y4, e.y);
                checkOutput("dut4 y_valid cycle", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (yv16) begin
            if (q16.size() == 0) begin
                reportFailure("dut16 unexpected y_valid");
            end else begin
                e = q16.pop_front();
                checkOutput("dut16 y_out", y16, e.y);
                checkOutput("dut16 y_valid cycle", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    // Called right after a negedge; leaves init low one cycle later, still before the next posedge.
    task automatic doInit(input logic [127:0] key);
        init  = 1'b1;
        h_key = key;
        #1;
        checkOutput("blk_ready low during init", 128'(ready1), 128'd0);
        @(negedge clk);
        init = 1'b0;
        #1;
        checkOutput("y_out cleared by init", y1, 128'd0);
    endtask

    task automatic applyStimulus(input logic [127:0] data, input logic [127:0] expected,
                                 input bit push, input bit fast);
        int t;
        int hs;
        blk_data  = data;
        blk_valid = 1'b1;
        if (fast) blk_valid_fast = 1'b1;
        #1;
        t = 0;
        while (!ready1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) reportFailure("handshake timeout");
        hs = cyc;
        if (push) q1.push_back('{y: expected, cyc: hs + 129});
        if (fast) begin
            q4.push_back('{y: expected, cyc: hs + 33});
            q16.push_back('{y: expected, cyc: hs + 9});
        end
        @(negedge clk);
        blk_valid      = 1'b0;
        blk_valid_fast = 1'b0;
    endtask

    task automatic waitIdle();
        int t;
        t = 0;
        while (!ready1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) reportFailure("idle timeout");
    endtask

    initial begin
        int  t;
        int  hs;
        bit  bad;

        rst            = 1'b1;
        init           = 1'b0;
        h_key          = '0;
        blk_valid      = 1'b0;
        blk_valid_fast = 1'b0;
        blk_data       = '0;
        #2;
        checkOutput("reset y_out", y1, 128'd0);
        checkOutput("reset y_valid", 128'(yv1), 128'd0);
        checkOutput("reset busy", 128'(busy1), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("blk_ready after reset", 128'(ready1), 128'd1);

        // Identity multiplier, then a back-to-back second block.
        @(negedge clk);
        doInit(H_ONE);
        applyStimulus(X_ID, X_ID, 1'b1, 1'b0);
        checkOutput("busy during MUL", 128'(busy1), 128'd1);
        waitIdle();
        checkOutput("busy low when done", 128'(busy1), 128'd0);
        applyStimulus(B_ID, XB_ID, 1'b1, 1'b0);
        waitIdle();

        // Single reduction step.
        doInit(128'h1);
        applyStimulus(X_RED, Y_RED, 1'b1, 1'b0);
        waitIdle();

        // NIST test case 2 across all three widths.
        doInit(H_NIST);
        applyStimulus(X_NIST, Y_NIST, 1'b1, 1'b1);
        waitIdle();

        // Backpressure: second block held on the bus during the first multiply.
        doInit(H_ONE);
        blk_data  = A_BP;
        blk_valid = 1'b1;
        #1;
        hs = cyc;
        checkOutput("bp first accept ready", 128'(ready1), 128'd1);
        q1.push_back('{y: A_BP, cyc: hs + 129});
        @(negedge clk);
        blk_data = B_BP;
        bad = 1'b0;
        for (int k = 1; k <= 128; k++) begin
            if (ready1 || !busy1) bad = 1'b1;
            @(negedge clk);
        end
        checkOutput("bp ready low through MUL", 128'(bad), 128'd0);
        checkOutput("bp ready back with y_valid", 128'(ready1), 128'd1);
        hs = cyc;
        q1.push_back('{y: AB_BP, cyc: hs + 129});
        @(negedge clk);
        blk_valid = 1'b0;
        waitIdle();

        // Abort at cnt == 50 with a new key; the next block uses the new key.
        doInit(H_ONE);
        applyStimulus(X_ID, X_ID, 1'b0, 1'b0);
        repeat (50) @(negedge clk);
        checkOutput("busy before abort", 128'(busy1), 128'd1);
        init  = 1'b1;
        h_key = 128'h1;
        @(negedge clk);
        init = 1'b0;
        #1;
        checkOutput("abort y_out", y1, 128'd0);
        checkOutput("abort busy", 128'(busy1), 128'd0);
        checkOutput("abort ready", 128'(ready1), 128'd1);
        applyStimulus(X_RED, Y_RED, 1'b1, 1'b0);
        waitIdle();

        // Asynchronous reset mid-multiply, then a block with H back at zero.
        applyStimulus(X_ID, X_ID, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset y_out", y1, 128'd0);
        checkOutput("async reset y_valid", 128'(yv1), 128'd0);
        checkOutput("async reset busy", 128'(busy1), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("ready after async reset", 128'(ready1), 128'd1);
        applyStimulus(X_ID, 128'd0, 1'b1, 1'b0);
        waitIdle();

        t = 0;
        while ((q1.size() != 0 || q4.size() != 0 || q16.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        checkOutput("dut1 queue drained", 128'(q1.size()), 128'd0);
        checkOutput("dut4 queue drained", 128'(q4.size()), 128'd0);
        checkOutput("dut16 queue drained", 128'(q16.size()), 128'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
